arp_resolver: RTL and testbench

- Initiator side of ARP: the counterpart to the reply/request trigger control.
- Given an IPv4 address, decides whether a request is needed and issues it to the ARP transmitter.
- Waits for the matching reply, retries on timeout, and returns the resolved MAC from a single-entry cache.
- Also queues replies to incoming ARP requests and arbitrates them against its own requests, so it is the sole driver of the transmitter's arp_tx_en/arp_tx_type.

---
 rtl/eth_arp_pkg.sv | 13 +
 rtl/arp_retry_timer.sv | 39 +++
 rtl/arp_resolver.sv | 225 ++++++++++++++++++++++
 tb/tb_arp_resolver.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_arp_pkg.sv
// Shared ARP constants and resolver FSM state encoding.
package eth_arp_pkg;

    localparam logic        ARP_OP_REQ  = 1'b0;
    localparam logic        ARP_OP_RPLY = 1'b1;
    localparam logic [47:0] BCAST_MAC   = 48'hFFFF_FFFF_FFFF;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SEND      = 2'd1;
    localparam logic [1:0] ST_WAIT_TX   = 2'd2;
    localparam logic [1:0] ST_WAIT_RPLY = 2'd3;

endpackage

// File: rtl/arp_retry_timer.sv
// Reply timeout counter: counts while enabled, pulses expire on its last cycle.
module arp_retry_timer #(
    parameter int TIMEOUT_CYC = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int            CW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expire = en && (count_q == LAST);

    // Next count: clear wins, wrap on expiry so the counter never leaves range.
    always_comb begin
        count_d = count_q;
        if (clr || expire) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/arp_resolver.sv
// ARP initiator: resolves an IPv4 address through a single-entry cache or a
// request/retry sequence, and answers incoming requests for the board IP.
// It is the only driver of the transmitter start/type controls.
module arp_resolver
    import eth_arp_pkg::*;
#(
    parameter int          TIMEOUT_CYC = 12_500_000,
    parameter int          MAX_RETRY   = 3,
    parameter logic [31:0] BOARD_IP    = 32'hC0A8_010A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        resolve_req,
    input  logic [31:0] resolve_ip,
    input  logic        arp_rx_done,
    input  logic        arp_rx_type,
    input  logic [31:0] rx_src_ip,
    input  logic [47:0] rx_src_mac,
    input  logic [31:0] rx_dst_ip,
    input  logic        arp_tx_done,
    output logic        arp_tx_en,
    output logic        arp_tx_type,
    output logic [31:0] tx_des_ip,
    output logic [47:0] tx_des_mac,
    output logic        busy,
    output logic        resolve_done,
    output logic        resolve_fail,
    output logic [47:0] resolved_mac
);

    localparam int            RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    logic [1:0]    state_q,        state_d;
    logic [31:0]   target_ip_q,    target_ip_d;
    logic [RW-1:0] retry_cnt_q,    retry_cnt_d;
    logic          cache_valid_q,  cache_valid_d;
    logic [31:0]   cache_ip_q,     cache_ip_d;
    logic [47:0]   cache_mac_q,    cache_mac_d;
    logic          reply_pend_q,   reply_pend_d;
    logic [31:0]   rp_ip_q,        rp_ip_d;
    logic [47:0]   rp_mac_q,       rp_mac_d;
    logic          tx_busy_q,      tx_busy_d;
    logic          tx_en_q,        tx_en_d;
    logic          tx_type_q,      tx_type_d;
    logic [31:0]   des_ip_q,       des_ip_d;
    logic [47:0]   des_mac_q,      des_mac_d;
    logic          done_q,         done_d;
    logic          fail_q,         fail_d;
    logic [47:0]   res_mac_q,      res_mac_d;

    logic timer_clr;
    logic timer_en;
    logic timer_expire;
    logic rx_match;
    logic rx_req_board;

    assign timer_en  = (state_q == ST_WAIT_RPLY);
    assign timer_clr = !timer_en;

    assign rx_match = arp_rx_done && (arp_rx_type == ARP_OP_RPLY) &&
                      (rx_src_ip == target_ip_q) &&
                      ((state_q == ST_WAIT_TX) || (state_q == ST_WAIT_RPLY));

    assign rx_req_board = arp_rx_done && (arp_rx_type == ARP_OP_REQ) &&
                          (rx_dst_ip == BOARD_IP);

    arp_retry_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (timer_clr),
        .en    (timer_en),
        .expire(timer_expire)
    );

    // Cache upkeep, reply queue, transmit arbitration and resolver FSM.
    always_comb begin
        state_d       = state_q;
        target_ip_d   = target_ip_q;
        retry_cnt_d   = retry_cnt_q;
        cache_valid_d = cache_valid_q;
        cache_ip_d    = cache_ip_q;
        cache_mac_d   = cache_mac_q;
        reply_pend_d  = reply_pend_q;
        rp_ip_d       = rp_ip_q;
        rp_mac_d      = rp_mac_q;
        tx_busy_d     = tx_busy_q;
        tx_en_d       = 1'b0;
        tx_type_d     = tx_type_q;
        des_ip_d      = des_ip_q;
        des_mac_d     = des_mac_q;
        done_d        = 1'b0;
        fail_d        = 1'b0;
        res_mac_d     = res_mac_q;

        // Any frame from the cached host refreshes its MAC.
        if (arp_rx_done && cache_valid_q && (rx_src_ip == cache_ip_q)) begin
            cache_mac_d = rx_src_mac;
        end

        if (arp_tx_done) begin
            tx_busy_d = 1'b0;
        end

        // Pending replies go out ahead of our own requests.
        if (!tx_busy_q) begin
            if (reply_pend_q) begin
                tx_en_d      = 1'b1;
                tx_type_d    = ARP_OP_RPLY;
                des_ip_d     = rp_ip_q;
                des_mac_d    = rp_mac_q;
                reply_pend_d = 1'b0;
                tx_busy_d    = 1'b1;
            end else if (state_q == ST_SEND) begin
                tx_en_d   = 1'b1;
                tx_type_d = ARP_OP_REQ;
                des_ip_d  = target_ip_q;
                des_mac_d = BCAST_MAC;
                tx_busy_d = 1'b1;
                state_d   = ST_WAIT_TX;
            end
        end

        // Placed after the launch so a request arriving in the launch cycle is still queued.
        if (rx_req_board) begin
            reply_pend_d = 1'b1;
            rp_ip_d      = rx_src_ip;
            rp_mac_d     = rx_src_mac;
        end

        if (rx_match) begin
            cache_valid_d = 1'b1;
            cache_ip_d    = rx_src_ip;
            cache_mac_d   = rx_src_mac;
            res_mac_d     = rx_src_mac;
            done_d        = 1'b1;
            state_d       = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (resolve_req) begin
                        if (cache_valid_q && (resolve_ip == cache_ip_q)) begin
                            res_mac_d = cache_mac_q;
                            done_d    = 1'b1;
                        end else begin
                            target_ip_d = resolve_ip;
                            retry_cnt_d = '0;
                            state_d     = ST_SEND;
                        end
                    end
                end
                ST_WAIT_TX: begin
                    if (arp_tx_done) begin
                        state_d = ST_WAIT_RPLY;
                    end
                end
                ST_WAIT_RPLY: begin
                    if (timer_expire) begin
                        if (retry_cnt_q < RETRY_MAX) begin
                            retry_cnt_d = retry_cnt_q + RW'(1);
                            state_d     = ST_SEND;
                        end else begin
                            fail_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State, cache, queue and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            target_ip_q   <= '0;
            retry_cnt_q   <= '0;
            cache_valid_q <= 1'b0;
            cache_ip_q    <= '0;
            cache_mac_q   <= '0;
            reply_pend_q  <= 1'b0;
            rp_ip_q       <= '0;
            rp_mac_q      <= '0;
            tx_busy_q     <= 1'b0;
            tx_en_q       <= 1'b0;
            tx_type_q     <= 1'b0;
            des_ip_q      <= '0;
            des_mac_q     <= '0;
            done_q        <= 1'b0;
            fail_q        <= 1'b0;
            res_mac_q     <= '0;
        end else begin
            state_q       <= state_d;
            target_ip_q   <= target_ip_d;
            retry_cnt_q   <= retry_cnt_d;
            cache_valid_q <= cache_valid_d;
            cache_ip_q    <= cache_ip_d;
            cache_mac_q   <= cache_mac_d;
            reply_pend_q  <= reply_pend_d;
            rp_ip_q       <= rp_ip_d;
            rp_mac_q      <= rp_mac_d;
            tx_busy_q     <= tx_busy_d;
            tx_en_q       <= tx_en_d;
            tx_type_q     <= tx_type_d;
            des_ip_q      <= des_ip_d;
            des_mac_q     <= des_mac_d;
            done_q        <= done_d;
            fail_q        <= fail_d;
            res_mac_q     <= res_mac_d;
        end
    end

    assign arp_tx_en    = tx_en_q;
    assign arp_tx_type  = tx_type_q;
    assign tx_des_ip    = des_ip_q;
    assign tx_des_mac   = des_mac_q;
    assign busy         = (state_q != ST_IDLE);
    assign resolve_done = done_q;
    assign resolve_fail = fail_q;
    assign resolved_mac = res_mac_q;

endmodule

// File: tb/tb_arp_resolver.sv
// Directed bench for arp_resolver with a transmitter model (10-cycle frames).
module tb_arp_resolver;

    localparam int          TX_LEN = 10;
    localparam logic [31:0] BOARD  = 32'hC0A8_010A;
    localparam logic [31:0] IP_A   = 32'hC0A8_0166;
    localparam logic [31:0] IP_B   = 32'hC0A8_0199;
    localparam logic [31:0] IP_C   = 32'hC0A8_0177;
    localparam logic [31:0] IP_D   = 32'hC0A8_0188;
    localparam logic [31:0] IP_R   = 32'hC0A8_0102;
    localparam logic [47:0] MAC_A  = 48'h00_11_22_33_44_55;
    localparam logic [47:0] MAC_C  = 48'hA0_A1_A2_A3_A4_A5;
    localparam logic [47:0] MAC_C2 = 48'hB0_B1_B2_B3_B4_B5;
    localparam logic [47:0] MAC_R  = 48'h0A_0B_0C_0D_0E_0F;
    localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;
    // Reply window: 100 timeout cycles, one cycle in SEND, one for the registered launch.
    localparam int          RETRY_GAP = 102;

    logic        clk = 1'b0;
    logic        rst;
    logic        resolve_req;
    logic [31:0] resolve_ip;
    logic        arp_rx_done;
    logic        arp_rx_type;
    logic [31:0] rx_src_ip;
    logic [47:0] rx_src_mac;
    logic [31:0] rx_dst_ip;
    logic        arp_tx_done;
    logic        arp_tx_en;
    logic        arp_tx_type;
    logic [31:0] tx_des_ip;
    logic [47:0] tx_des_mac;
    logic        busy;
    logic        resolve_done;
    logic        resolve_fail;
    logic [47:0] resolved_mac;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic        ev_type[$];
    logic [31:0] ev_ip[$];
    logic [47:0] ev_mac[$];
    int          ev_cyc[$];
    int          dn_cyc[$];
    int          done_cnt = 0;
    int          fail_cnt = 0;
    int          done_at  = -1;
    int          fail_at  = -1;
    logic        busy_at_fail = 1'b1;

    arp_resolver #(
        .TIMEOUT_CYC(100),
        .MAX_RETRY  (3),
        .BOARD_IP   (BOARD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .resolve_req (resolve_req),
        .resolve_ip  (resolve_ip),
        .arp_rx_done (arp_rx_done),
        .arp_rx_type (arp_rx_type),
        .rx_src_ip   (rx_src_ip),
        .rx_src_mac  (rx_src_mac),
        .rx_dst_ip   (rx_dst_ip),
        .arp_tx_done (arp_tx_done),
        .arp_tx_en   (arp_tx_en),
        .arp_tx_type (arp_tx_type),
        .tx_des_ip   (tx_des_ip),
        .tx_des_mac  (tx_des_mac),
        .busy        (busy),
        .resolve_done(resolve_done),
        .resolve_fail(resolve_fail),
        .resolved_mac(resolved_mac)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model and output logger, sampled on the falling edge.
    initial begin : tx_model
        int left;
        left = 0;
        arp_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            arp_tx_done = 1'b0;
            if (left > 0) begin
                left--;
                if (left == 0) begin
                    arp_tx_done = 1'b1;
                    dn_cyc.push_back(cyc);
                end
            end
            if (arp_tx_en === 1'b1) begin
                ev_type.push_back(arp_tx_type);
                ev_ip.push_back(tx_des_ip);
                ev_mac.push_back(tx_des_mac);
                ev_cyc.push_back(cyc);
                left = TX_LEN;
            end
            if (resolve_done === 1'b1) begin
                done_cnt++;
                done_at = cyc;
            end
            if (resolve_fail === 1'b1) begin
                fail_cnt++;
                fail_at = cyc;
                busy_at_fail = busy;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_resolve(input logic [31:0] ip, output int at);
        @(negedge clk);
        resolve_req = 1'b1;
        resolve_ip  = ip;
        at = cyc;
        @(negedge clk);
        resolve_req = 1'b0;
    endtask

    task automatic do_rx(input logic typ, input logic [31:0] sip, input logic [47:0] smac,
                         input logic [31:0] dip, output int at);
        @(negedge clk);
        arp_rx_type = typ;
        rx_src_ip   = sip;
        rx_src_mac  = smac;
        rx_dst_ip   = dip;
        arp_rx_done = 1'b1;
        at = cyc;
        @(negedge clk);
        arp_rx_done = 1'b0;
    endtask

    // which: 0 = tx starts, 1 = tx dones, 2 = resolve_done, 3 = resolve_fail
    task automatic wait_cnt(input int which, input int n, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(posedge clk);
            #1;
            case (which)
                0:       ok = (ev_cyc.size() >= n);
                1:       ok = (dn_cyc.size() >= n);
                2:       ok = (done_cnt >= n);
                default: ok = (fail_cnt >= n);
            endcase
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        checks++; if ({arp_tx_en, arp_tx_type, busy, resolve_done, resolve_fail} !== 5'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=00000", {arp_tx_en, arp_tx_type, busy, resolve_done, resolve_fail}); end
        checks++; if ({tx_des_ip, tx_des_mac, resolved_mac} !== 128'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", {tx_des_ip, tx_des_mac, resolved_mac}); end
        @(negedge clk);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_resolve_miss();
        int r, x, n0, dn0, d0;
        bit ok;
        n0 = ev_cyc.size(); dn0 = dn_cyc.size(); d0 = done_cnt;
        do_resolve(IP_A, r);
        wait_cnt(1, dn0 + 1, 200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL miss_txdone got=timeout exp=tx_done"); end
        checks++; if (ev_cyc.size() !== n0 + 1) begin failures++; $display("FAIL miss_txcnt got=%0d exp=%0d", ev_cyc.size(), n0 + 1); end
        checks++; if (ev_type[n0] !== 1'b0) begin failures++; $display("FAIL miss_type got=%b exp=0", ev_type[n0]); end
        checks++; if (ev_ip[n0] !== IP_A) begin failures++; $display("FAIL miss_ip got=%h exp=%h", ev_ip[n0], IP_A); end
        checks++; if (ev_mac[n0] !== BCAST) begin failures++; $display("FAIL miss_mac got=%h exp=%h", ev_mac[n0], BCAST); end
        checks++; if (ev_cyc[n0] - r !== 2) begin failures++; $display("FAIL miss_latency got=%0d exp=2", ev_cyc[n0] - r); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL miss_busy got=%b exp=1", busy); end
        tick(19);
        do_rx(1'b1, IP_A, MAC_A, BOARD, x);
        wait_cnt(2, d0 + 1, 20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL miss_done got=timeout exp=resolve_done"); end
        checks++; if (done_at !== x + 1) begin failures++; $display("FAIL miss_done_cyc got=%0d exp=%0d", done_at, x + 1); end
        checks++; if (resolved_mac !== MAC_A) begin failures++; $display("FAIL miss_rmac got=%h exp=%h", resolved_mac, MAC_A); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL miss_idle got=%b exp=0", busy); end
    endtask

    task automatic test_cache_hit();
        int r, n0, d0;
        n0 = ev_cyc.size(); d0 = done_cnt;
        do_resolve(IP_A, r);
        tick(5);
        checks++; if (done_cnt !== d0 + 1) begin failures++; $display("FAIL hit_done got=%0d exp=%0d", done_cnt, d0 + 1); end
        checks++; if (done_at !== r + 1) begin failures++; $display("FAIL hit_latency got=%0d exp=%0d", done_at, r + 1); end
        checks++; if (ev_cyc.size() !== n0) begin failures++; $display("FAIL hit_notx got=%0d exp=%0d", ev_cyc.size(), n0); end
        checks++; if (resolved_mac !== MAC_A) begin failures++; $display("FAIL hit_rmac got=%h exp=%h", resolved_mac, MAC_A); end
    endtask

    task automatic test_retry_fail();
        int r, n0, dn0, d0, f0;
        bit ok;
        n0 = ev_cyc.size(); dn0 = dn_cyc.size(); d0 = done_cnt; f0 = fail_cnt;
        do_resolve(IP_B, r);
        wait_cnt(3, f0 + 1, 1000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL fail_pulse got=timeout exp=resolve_fail"); end
        checks++; if (ev_cyc.size() !== n0 + 4) begin failures++; $display("FAIL fail_txcnt got=%0d exp=%0d", ev_cyc.size(), n0 + 4); end
        for (int i = 1; i < 4; i++) begin
            checks++; if (ev_cyc[n0 + i] - dn_cyc[dn0 + i - 1] !== RETRY_GAP) begin failures++; $display("FAIL fail_gap%0d got=%0d exp=%0d", i, ev_cyc[n0 + i] - dn_cyc[dn0 + i - 1], RETRY_GAP); end
            checks++; if ({ev_type[n0 + i], ev_ip[n0 + i]} !== {1'b0, IP_B}) begin failures++; $display("FAIL fail_req%0d got=%h exp=%h", i, {ev_type[n0 + i], ev_ip[n0 + i]}, {1'b0, IP_B}); end
        end
        checks++; if (fail_at !== dn_cyc[dn0 + 3] + 101) begin failures++; $display("FAIL fail_cyc got=%0d exp=%0d", fail_at, dn_cyc[dn0 + 3] + 101); end
        checks++; if (busy_at_fail !== 1'b0) begin failures++; $display("FAIL fail_busy got=%b exp=0", busy_at_fail); end
        checks++; if (done_cnt !== d0) begin failures++; $display("FAIL fail_nodone got=%0d exp=%0d", done_cnt, d0); end
    endtask

    task automatic test_reply_request();
        int r, x, n0, dn0, d0, dt, dc;
        bit ok;
        n0 = ev_cyc.size(); dn0 = dn_cyc.size(); dc = done_cnt;
        do_resolve(IP_C, r);
        wait_cnt(1, dn0 + 1, 200, ok);
        d0 = dn_cyc[dn0];
        tick(30);
        do_rx(1'b0, 32'hC0A8_0155, MAC_R, 32'hC0A8_0163, x);
        tick(5);
        checks++; if (ev_cyc.size() !== n0 + 1) begin failures++; $display("FAIL rq_foreign got=%0d exp=%0d", ev_cyc.size(), n0 + 1); end
        do_rx(1'b0, IP_R, MAC_R, BOARD, x);
        wait_cnt(0, n0 + 2, 20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rq_launch got=timeout exp=arp_tx_en"); end
        checks++; if ({ev_type[n0 + 1], ev_ip[n0 + 1], ev_mac[n0 + 1]} !== {1'b1, IP_R, MAC_R}) begin failures++; $display("FAIL rq_frame got=%h exp=%h", {ev_type[n0 + 1], ev_ip[n0 + 1], ev_mac[n0 + 1]}, {1'b1, IP_R, MAC_R}); end
        checks++; if (ev_cyc[n0 + 1] !== x + 2) begin failures++; $display("FAIL rq_latency got=%0d exp=%0d", ev_cyc[n0 + 1], x + 2); end
        wait_cnt(0, n0 + 3, 300, ok);
        checks++; if ({ok, ev_type[n0 + 2]} !== 2'b10) begin failures++; $display("FAIL rq_retry got=%b exp=10", {ok, ev_type[n0 + 2]}); end
        checks++; if (ev_cyc[n0 + 2] !== d0 + RETRY_GAP) begin failures++; $display("FAIL rq_timer got=%0d exp=%0d", ev_cyc[n0 + 2], d0 + RETRY_GAP); end
        do_rx(1'b1, IP_C, MAC_C, BOARD, x);
        wait_cnt(2, dc + 1, 20, ok);
        checks++; if ({ok, resolved_mac} !== {1'b1, MAC_C}) begin failures++; $display("FAIL rq_match got=%h exp=%h", {ok, resolved_mac}, {1'b1, MAC_C}); end
        checks++; if (done_at !== x + 1) begin failures++; $display("FAIL rq_done_cyc got=%0d exp=%0d", done_at, x + 1); end
        tick(15);
        n0 = ev_cyc.size(); dc = done_cnt;
        do_resolve(IP_C, r);
        tick(4);
        checks++; if ({done_cnt - dc, ev_cyc.size() - n0} !== {32'd1, 32'd0}) begin failures++; $display("FAIL rq_hit got=%0d,%0d exp=1,0", done_cnt - dc, ev_cyc.size() - n0); end
        dt = done_at - r;
        checks++; if (dt !== 1) begin failures++; $display("FAIL rq_hit_cyc got=%0d exp=1", dt); end
    endtask

    task automatic test_back_to_back();
        int r, x, n0, dn0, d;
        bit ok;
        n0 = ev_cyc.size(); dn0 = dn_cyc.size();
        do_resolve(IP_D, r);
        wait_cnt(1, dn0 + 1, 200, ok);
        d = dn_cyc[dn0];
        while (cyc < d + 99) @(negedge clk);
        do_rx(1'b0, IP_R, MAC_R, BOARD, x);
        wait_cnt(0, n0 + 2, 50, ok);
        checks++; if ({ok, ev_type[n0 + 1]} !== 2'b11) begin failures++; $display("FAIL b2b_reply_first got=%b exp=11", {ok, ev_type[n0 + 1]}); end
        checks++; if (ev_cyc[n0 + 1] !== d + RETRY_GAP) begin failures++; $display("FAIL b2b_reply_cyc got=%0d exp=%0d", ev_cyc[n0 + 1], d + RETRY_GAP); end
        wait_cnt(0, n0 + 3, 50, ok);
        checks++; if ({ok, ev_type[n0 + 2], ev_ip[n0 + 2]} !== {2'b10, IP_D}) begin failures++; $display("FAIL b2b_req got=%h exp=%h", {ok, ev_type[n0 + 2], ev_ip[n0 + 2]}, {2'b10, IP_D}); end
        checks++; if (ev_cyc[n0 + 2] !== dn_cyc[dn0 + 1] + 2) begin failures++; $display("FAIL b2b_req_cyc got=%0d exp=%0d", ev_cyc[n0 + 2], dn_cyc[dn0 + 1] + 2); end
    endtask

    task automatic test_async_reset();
        int r, x, n0, dn0, dc;
        bit ok;
        dn0 = dn_cyc.size();
        wait_cnt(1, 3, 50, ok);
        tick(20);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL arst_pre_busy got=%b exp=1", busy); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if ({arp_tx_en, arp_tx_type, busy, resolve_done, resolve_fail} !== 5'b0) begin failures++; $display("FAIL arst_ctrl got=%b exp=00000", {arp_tx_en, arp_tx_type, busy, resolve_done, resolve_fail}); end
        checks++; if ({tx_des_ip, tx_des_mac, resolved_mac} !== 128'd0) begin failures++; $display("FAIL arst_data got=%h exp=0", {tx_des_ip, tx_des_mac, resolved_mac}); end
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        n0 = ev_cyc.size(); dc = done_cnt;
        do_resolve(IP_C, r);
        wait_cnt(0, n0 + 1, 20, ok);
        checks++; if ({ok, ev_type[n0], ev_ip[n0]} !== {2'b10, IP_C}) begin failures++; $display("FAIL arst_miss got=%h exp=%h", {ok, ev_type[n0], ev_ip[n0]}, {2'b10, IP_C}); end
        checks++; if (ev_cyc[n0] - r !== 2) begin failures++; $display("FAIL arst_latency got=%0d exp=2", ev_cyc[n0] - r); end
        checks++; if (done_cnt !== dc) begin failures++; $display("FAIL arst_nohit got=%0d exp=%0d", done_cnt, dc); end
        do_rx(1'b1, IP_C, MAC_C2, BOARD, x);
        wait_cnt(2, dc + 1, 20, ok);
        checks++; if ({ok, resolved_mac} !== {1'b1, MAC_C2}) begin failures++; $display("FAIL arst_resolve got=%h exp=%h", {ok, resolved_mac}, {1'b1, MAC_C2}); end
        if (dn0 < 0) failures++;
    endtask

    initial begin
        rst         = 1'b1;
        resolve_req = 1'b0;
        resolve_ip  = '0;
        arp_rx_done = 1'b0;
        arp_rx_type = 1'b0;
        rx_src_ip   = '0;
        rx_src_mac  = '0;
        rx_dst_ip   = '0;
        test_reset();
        test_resolve_miss();
        test_cache_hit();
        test_retry_fail();
        test_reply_request();
        test_back_to_back();
        test_async_reset();
        tick(20);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
